binary_adder: RTL and testbench
===============================

Name: binary_adder

Overview:
- Binary addition primitive for the datapath; used by bcd_to_binary and similar converters.
- Two independent paths:
  - a zero-latency combinational 1-bit full adder (fa_*), the cell used for ripple and serial chaining;
  - a clocked bit-serial WIDTH-bit adder engine with a start/busy/done handshake, running one full-adder step per cycle, LSB first, with an internal carry register.

Parameters:
- WIDTH, 8, operand/result width of the serial engine; legal range 1..32.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- fa_a  in  1  full-adder operand A
- fa_b  in  1  full-adder operand B
- fa_cin  in  1  full-adder carry in
- fa_sum  out  1  fa_a ^ fa_b ^ fa_cin
- fa_cout  out  1  majority(fa_a, fa_b, fa_cin)
- start  in  1  request serial add; sampled only when busy=0
- a  in  WIDTH  serial operand A, captured at accepted start
- b  in  WIDTH  serial operand B, captured at accepted start
- cin  in  1  serial carry in, captured at accepted start
- busy  out  1  engine computing
- done  out  1  one-cycle pulse: sum/cout valid and updated
- sum  out  WIDTH  registered result, (a+b+cin) mod 2^WIDTH
- cout  out  1  registered carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Full-adder path:
  - purely combinational, no clock or reset dependency;
  - outputs settle in the same delta as their inputs.
- Reset (rst_n=0, asynchronous): busy=0, done=0, sum=0, cout=0; internal operand shift registers, carry register and bit counter cleared.
- Reset asserted mid-operation aborts the add; no done is produced.
- Serial engine states:
  - IDLE (busy=0);
  - RUN (busy=1).
- Accept: at a clk edge with start=1 and busy=0:
  - latch a, b into shift registers;
  - carry_reg <= cin; bit counter <= 0;
  - busy <= 1.
- start while busy=1 is ignored (no queueing, operands not re-latched).
- RUN, each edge:
  - full adder applied to (a_sr[0], b_sr[0], carry_reg);
  - sum bit shifted into the result register from the MSB side;
  - carry_reg <= carry out;
  - operand registers shift right; counter increments.
- Completion, on the edge processing bit WIDTH-1:
  - busy <= 0, done <= 1;
  - sum <= full result; cout <= final carry.
- Latency: accepted start at edge N gives done=1 during the cycle after edge N+WIDTH. Exactly WIDTH cycles of busy=1.
- done:
  - high exactly one cycle;
  - cleared on the next edge regardless of start.
- Start accepted in the done cycle: valid, since busy=0. New run begins; done still drops next edge.
- sum/cout hold their last result until the next completion. They do not change during RUN; partial results stay internal.
- WIDTH=1: RUN lasts one cycle; result equals the fa cell output for the latched bits.

Optional Feature:
- Macro SERIAL_OVF_EN.
- Defined:
  - extra output port ovf (1 bit), registered alongside cout at completion;
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (two's-complement signed overflow);
  - reset value 0; holds until next completion.
- Undefined: port ovf and its logic are absent; all other behaviour identical.

Test Plan:
- fa path, all 8 combinations of fa_a/fa_b/fa_cin: fa_sum/fa_cout match the truth table (e.g. 1,1,1 -> sum 1, cout 1; 1,0,1 -> sum 0, cout 1).
- WIDTH=8, start with a=0x5A, b=0x3C, cin=0:
  - busy high 8 cycles;
  - done one cycle later with sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. Second start issued in the done cycle of the first.
- start pulsed with a=0x11 mid-run of a=0x0A, b=0x05:
  - result is 0x0F;
  - no extra done;
  - busy length unchanged.
- rst_n dropped at bit 4 of a run:
  - busy, done, sum, cout go 0 immediately;
  - no done after release;
  - a fresh start then completes correctly.
- With SERIAL_OVF_EN:
  - 0x7F+0x01 -> sum=0x80, ovf=1, cout=0;
  - 0xFF+0x01 -> ovf=0, cout=1.

Source files
------------

// File: rtl/binary_adder.sv
// Combinational full-adder cell plus a bit-serial WIDTH-bit adder engine.
// Define SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module binary_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fa_a,
    input  logic             fa_b,
    input  logic             fa_cin,
    output logic             fa_sum,
    output logic             fa_cout,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             step_sum;
    logic             step_cout;
    logic             last_bit;
    logic [WIDTH:0]   res_ext;
`ifdef SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    assign step_sum  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign step_cout = (a_sr_q[0] & b_sr_q[0])
                     | (a_sr_q[0] & carry_q)
                     | (b_sr_q[0] & carry_q);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    // Result fills from the MSB side so bit 0 lands last at position 0
    assign res_ext   = {step_sum, res_q};

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = res_ext[WIDTH:1];
                carry_d = step_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    sum_d   = res_ext[WIDTH:1];
                    cout_d  = step_cout;
`ifdef SERIAL_OVF_EN
                    // carry_q is the carry into the MSB on this step
                    ovf_d   = carry_q ^ step_cout;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_binary_adder.sv
// Directed self-checking bench for binary_adder (WIDTH=8).
module tb_binary_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       fa_a = 1'b0;
    logic       fa_b = 1'b0;
    logic       fa_cin = 1'b0;
    logic       fa_sum;
    logic       fa_cout;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    binary_adder #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fa_a(fa_a),
        .fa_b(fa_b),
        .fa_cin(fa_cin),
        .fa_sum(fa_sum),
        .fa_cout(fa_cout),
        .start(start),
        .a(a),
        .b(b),
        .cin(cin),
        .busy(busy),
        .done(done),
        .sum(sum),
        .cout(cout)
`ifdef SERIAL_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                            input logic cv);
        a = av;
        b = bv;
        cin = cv;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Waits for done; optionally pulses a start at loop index inj_at.
    task automatic wait_done(input int inj_at, output int busy_n,
                             output bit seen, output bit held);
        logic [7:0] s0;
        logic       c0;
        s0 = sum;
        c0 = cout;
        busy_n = 0;
        seen = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (sum !== s0 || cout !== c0) held = 1'b0;
            if (i == inj_at) begin
                a = 8'h11;
                b = 8'h11;
                cin = 1'b1;
                start = 1'b1;
            end
            tick;
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: sum=%h cout=%b want 00 0", sum, cout);
        end
    endtask

    task automatic test_fa;
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [2:0] v;
        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            fa_a = v[2];
            fa_b = v[1];
            fa_cin = v[0];
            #1;
            checks++;
            if (fa_sum !== exp_s[i] || fa_cout !== exp_c[i]) begin
                errors++;
                $display("FAIL fa_%b: sum=%b cout=%b want %b %b",
                         v, fa_sum, fa_cout, exp_s[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_basic;
        int bn;
        bit seen;
        bit held;
        start_op(8'h5A, 8'h3C, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_start: busy=%b want 1", busy);
        end
        wait_done(-1, bn, seen, held);
        checks++;
        if (!seen || bn != 8) begin
            errors++;
            $display("FAIL basic_latency: seen=%b busy_cycles=%0d want 1 8",
                     seen, bn);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL basic_hold: result moved during run, want held");
        end
        checks++;
        if (sum !== 8'h96 || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: sum=%h cout=%b want 96 0", sum, cout);
        end
        tick;
        checks++;
        if (done !== 1'b0 || sum !== 8'h96) begin
            errors++;
            $display("FAIL basic_after: done=%b sum=%h want 0 96", done, sum);
        end
    endtask

    task automatic test_back_to_back;
        int bn;
        bit seen;
        bit held;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(-1, bn, seen, held);
        checks++;
        if (!seen || sum !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: seen=%b sum=%h cout=%b want 1 00 1",
                     seen, sum, cout);
        end
        start_op(8'h00, 8'h00, 1'b1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: done=%b busy=%b want 0 1", done, busy);
        end
        wait_done(-1, bn, seen, held);
        checks++;
        if (!seen || bn != 8 || !held) begin
            errors++;
            $display("FAIL b2b_run: seen=%b busy_cycles=%0d held=%b want 1 8 1",
                     seen, bn, held);
        end
        checks++;
        if (sum !== 8'h01 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: sum=%h cout=%b want 01 0", sum, cout);
        end
    endtask

    task automatic test_ignore_start;
        int bn;
        int extra;
        bit seen;
        bit held;
        start_op(8'h0A, 8'h05, 1'b0);
        wait_done(3, bn, seen, held);
        checks++;
        if (!seen || bn != 8) begin
            errors++;
            $display("FAIL ign_latency: seen=%b busy_cycles=%0d want 1 8",
                     seen, bn);
        end
        checks++;
        if (sum !== 8'h0F || cout !== 1'b0) begin
            errors++;
            $display("FAIL ign_sum: sum=%h cout=%b want 0f 0", sum, cout);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ign_extra: extra_active=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int bn;
        int extra;
        bit seen;
        bit held;
        start_op(8'hA5, 8'hC3, 1'b0);
        for (int i = 0; i < 4; i++) tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_ctl: busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL rmid_data: sum=%h cout=%b want 00 0", sum, cout);
        end
        #10 rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL rmid_nodone: active=%0d want 0", extra);
        end
        start_op(8'h12, 8'h34, 1'b1);
        wait_done(-1, bn, seen, held);
        checks++;
        if (!seen || bn != 8 || sum !== 8'h47 || cout !== 1'b0) begin
            errors++;
            $display("FAIL rmid_fresh: seen=%b cyc=%0d sum=%h cout=%b want 1 8 47 0",
                     seen, bn, sum, cout);
        end
    endtask

`ifdef SERIAL_OVF_EN
    task automatic test_ovf;
        int bn;
        bit seen;
        bit held;
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(-1, bn, seen, held);
        checks++;
        if (!seen || sum !== 8'h80 || ovf !== 1'b1 || cout !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pos: sum=%h ovf=%b cout=%b want 80 1 0",
                     sum, ovf, cout);
        end
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(-1, bn, seen, held);
        checks++;
        if (!seen || sum !== 8'h00 || ovf !== 1'b0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg: sum=%h ovf=%b cout=%b want 00 0 1",
                     sum, ovf, cout);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_fa;
        #4 rst_n = 1'b1;
        tick;
        test_basic;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
`ifdef SERIAL_OVF_EN
        test_ovf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
